// File: rtl/awg_cmd_ctrl_if.sv
// Byte input and configuration-register outputs of the AWG command controller.
// The slave side is the controller; the master side feeds bytes and watches the registers.
interface awg_cmd_ctrl_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [4:0]  wave_sel;
  logic [11:0] freq;
  logic [7:0]  amp;
  logic [7:0]  phase;
  logic        cfg_update;
  logic [1:0]  cfg_field;
  logic        err;
  logic [1:0]  err_code;
  logic        busy;

  modport master (
    output rx_data, rx_valid,
    input  wave_sel, freq, amp, phase, cfg_update, cfg_field, err, err_code, busy
  );

  modport slave (
    input  rx_data, rx_valid,
    output wave_sel, freq, amp, phase, cfg_update, cfg_field, err, err_code, busy
  );
endinterface

// File: rtl/awg_cmd_ctrl.sv
// Parses ASCII "<letter><digits><CR|LF>" commands into AWG config registers; results one cycle after the terminator.
// No backpressure: every rx_valid byte is consumed, so back-to-back commands need no gap.
module awg_cmd_ctrl #(
  parameter logic [4:0]  DEF_WAVE    = 5'd3,
  parameter logic [11:0] DEF_FREQ    = 12'd1,
  parameter logic [7:0]  DEF_AMP     = 8'd50,
  parameter logic [7:0]  DEF_PHASE   = 8'd50,
  parameter int unsigned WAVE_MAX    = 10,
  parameter int unsigned MAX_DIGITS  = 5,
  parameter logic [23:0] TIMEOUT_CYC = 24'd5_000_000
) (
  input  logic          clk,
  input  logic          rst,
  awg_cmd_ctrl_if.slave bus
);

  localparam int NDIG_W = $clog2(MAX_DIGITS + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIGITS = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

  state_t              r_state, w_state;
  logic [1:0]          r_field, w_field;
  logic [16:0]         r_acc, w_acc;
  logic [NDIG_W-1:0]   r_ndig, w_ndig;
  logic                r_ovf, w_ovf;
  logic [23:0]         r_tmo, w_tmo;
  logic [4:0]          r_wave, w_wave;
  logic [11:0]         r_freq, w_freq;
  logic [7:0]          r_amp, w_amp;
  logic [7:0]          r_phase, w_phase;
  logic                r_cfg_update, w_cfg_update;
  logic [1:0]          r_cfg_field, w_cfg_field;
  logic                r_err, w_err;
  logic [1:0]          r_err_code, w_err_code;
  logic                r_busy, w_busy;

  logic                w_is_term;
  logic                w_is_digit;
  logic [3:0]          w_digit;
  logic [16:0]         w_fmax;
  logic                w_tmo_hit;

  assign w_is_term  = (bus.rx_data == 8'd13) || (bus.rx_data == 8'd10);
  assign w_is_digit = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);
  assign w_digit    = 4'(bus.rx_data - 8'h30);
  assign w_tmo_hit  = (r_tmo == TIMEOUT_CYC - 24'd1);

  always_comb begin
    w_fmax = 17'd255;
    case (r_field)
      2'd0:    w_fmax = 17'(WAVE_MAX);
      2'd1:    w_fmax = 17'd4095;
      default: w_fmax = 17'd255;
    endcase
  end

  always_comb begin
    w_state      = r_state;
    w_field      = r_field;
    w_acc        = r_acc;
    w_ndig       = r_ndig;
    w_ovf        = r_ovf;
    w_tmo        = r_tmo;
    w_wave       = r_wave;
    w_freq       = r_freq;
    w_amp        = r_amp;
    w_phase      = r_phase;
    w_cfg_update = 1'b0;
    w_cfg_field  = r_cfg_field;
    w_err        = 1'b0;
    w_err_code   = r_err_code;

    case (r_state)
      ST_IDLE: begin
        w_tmo = 24'd0;
        if (bus.rx_valid) begin
          case (bus.rx_data)
            "W", "w", "F", "f", "A", "a", "P", "p": begin
              case (bus.rx_data)
                "W", "w": w_field = 2'd0;
                "F", "f": w_field = 2'd1;
                "A", "a": w_field = 2'd2;
                default:  w_field = 2'd3;
              endcase
              w_acc   = 17'd0;
              w_ndig  = '0;
              w_ovf   = 1'b0;
              w_state = ST_DIGITS;
            end
            8'd13, 8'd10, 8'd32: ;
            default: begin
              w_err      = 1'b1;
              w_err_code = 2'd0;
            end
          endcase
        end
      end

      ST_DIGITS: begin
        if (bus.rx_valid) begin
          w_tmo = 24'd0;
          if (w_is_digit) begin
            // ndig < MAX_DIGITS bounds acc so acc*10+9 stays within 17 bits
            if (r_ndig < NDIG_W'(MAX_DIGITS)) begin
              w_acc  = r_acc * 17'd10 + {13'd0, w_digit};
              w_ndig = r_ndig + NDIG_W'(1);
            end else begin
              w_ovf = 1'b1;
            end
          end else if (w_is_term) begin
            w_state = ST_IDLE;
            if (r_ndig == '0) begin
              w_err      = 1'b1;
              w_err_code = 2'd2;
            end else if (r_ovf || (r_acc > w_fmax)) begin
              w_err      = 1'b1;
              w_err_code = 2'd1;
            end else begin
              case (r_field)
                2'd0:    w_wave  = r_acc[4:0];
                2'd1:    w_freq  = r_acc[11:0];
                2'd2:    w_amp   = r_acc[7:0];
                default: w_phase = r_acc[7:0];
              endcase
              w_cfg_update = 1'b1;
              w_cfg_field  = r_field;
            end
          end else begin
            w_err      = 1'b1;
            w_err_code = 2'd0;
            w_state    = ST_FLUSH;
          end
        end else if (w_tmo_hit) begin
          w_err      = 1'b1;
          w_err_code = 2'd3;
          w_state    = ST_IDLE;
          w_tmo      = 24'd0;
        end else begin
          w_tmo = r_tmo + 24'd1;
        end
      end

      ST_FLUSH: begin
        if (bus.rx_valid) begin
          w_tmo = 24'd0;
          if (w_is_term) w_state = ST_IDLE;
        end else if (w_tmo_hit) begin
          w_err      = 1'b1;
          w_err_code = 2'd3;
          w_state    = ST_IDLE;
          w_tmo      = 24'd0;
        end else begin
          w_tmo = r_tmo + 24'd1;
        end
      end

      default: w_state = ST_IDLE;
    endcase

    w_busy = (w_state != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_field      <= 2'd0;
      r_acc        <= 17'd0;
      r_ndig       <= '0;
      r_ovf        <= 1'b0;
      r_tmo        <= 24'd0;
      r_wave       <= DEF_WAVE;
      r_freq       <= DEF_FREQ;
      r_amp        <= DEF_AMP;
      r_phase      <= DEF_PHASE;
      r_cfg_update <= 1'b0;
      r_cfg_field  <= 2'd0;
      r_err        <= 1'b0;
      r_err_code   <= 2'd0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_field      <= w_field;
      r_acc        <= w_acc;
      r_ndig       <= w_ndig;
      r_ovf        <= w_ovf;
      r_tmo        <= w_tmo;
      r_wave       <= w_wave;
      r_freq       <= w_freq;
      r_amp        <= w_amp;
      r_phase      <= w_phase;
      r_cfg_update <= w_cfg_update;
      r_cfg_field  <= w_cfg_field;
      r_err        <= w_err;
      r_err_code   <= w_err_code;
      r_busy       <= w_busy;
    end
  end

  assign bus.wave_sel   = r_wave;
  assign bus.freq       = r_freq;
  assign bus.amp        = r_amp;
  assign bus.phase      = r_phase;
  assign bus.cfg_update = r_cfg_update;
  assign bus.cfg_field  = r_cfg_field;
  assign bus.err        = r_err;
  assign bus.err_code   = r_err_code;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_awg_cmd_ctrl.sv
// Directed bench for awg_cmd_ctrl: bytes are driven on falling edges, registered outputs checked there too.
module tb_awg_cmd_ctrl;
  localparam logic [23:0] TMO = 24'd40;
  localparam int          T   = 40;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  awg_cmd_ctrl_if u_if ();

  awg_cmd_ctrl #(.TIMEOUT_CYC(TMO)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    u_if.rx_data  = b;
    u_if.rx_valid = 1'b1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic drop();
    @(negedge clk);
    u_if.rx_valid = 1'b0;
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b1;
    u_if.rx_data  = 8'd0;
    u_if.rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_wave", 32'(u_if.wave_sel), 3);
    check("rst_freq", 32'(u_if.freq), 1);
    check("rst_amp", 32'(u_if.amp), 50);
    check("rst_phase", 32'(u_if.phase), 50);
    check("rst_upd", 32'(u_if.cfg_update), 0);
    check("rst_err", 32'(u_if.err), 0);
    check("rst_busy", 32'(u_if.busy), 0);

    // F1000<CR> immediately followed by a200<LF>
    send_str("F1");
    check("f_busy", 32'(u_if.busy), 1);
    send_str("000");
    check("f_noupd", 32'(u_if.cfg_update), 0);
    send_byte(8'd13);
    send_byte("a");
    check("f_upd", 32'(u_if.cfg_update), 1);
    check("f_val", 32'(u_if.freq), 1000);
    check("f_fld", 32'(u_if.cfg_field), 1);
    check("f_err", 32'(u_if.err), 0);
    check("f_idle", 32'(u_if.busy), 0);
    send_byte("2");
    check("a_upd_pulse", 32'(u_if.cfg_update), 0);
    check("a_busy", 32'(u_if.busy), 1);
    send_str("00");
    send_byte(8'd10);
    drop();
    check("a_upd", 32'(u_if.cfg_update), 1);
    check("a_val", 32'(u_if.amp), 200);
    check("a_fld", 32'(u_if.cfg_field), 2);
    @(negedge clk);
    check("a_upd_off", 32'(u_if.cfg_update), 0);

    // Range and overflow rejections
    send_str("F4096");
    send_byte(8'd13);
    drop();
    check("f4096_err", 32'(u_if.err), 1);
    check("f4096_code", 32'(u_if.err_code), 1);
    check("f4096_upd", 32'(u_if.cfg_update), 0);
    check("f4096_freq", 32'(u_if.freq), 1000);
    @(negedge clk);
    check("f4096_pulse", 32'(u_if.err), 0);

    send_str("F123456");
    send_byte(8'd13);
    drop();
    check("ovf_err", 32'(u_if.err), 1);
    check("ovf_code", 32'(u_if.err_code), 1);
    check("ovf_freq", 32'(u_if.freq), 1000);

    send_str("W11");
    send_byte(8'd13);
    drop();
    check("w11_err", 32'(u_if.err), 1);
    check("w11_code", 32'(u_if.err_code), 1);
    check("w11_wave", 32'(u_if.wave_sel), 3);

    send_str("W10");
    send_byte(8'd13);
    drop();
    check("w10_wave", 32'(u_if.wave_sel), 10);
    check("w10_upd", 32'(u_if.cfg_update), 1);
    check("w10_fld", 32'(u_if.cfg_field), 0);
    check("w10_err", 32'(u_if.err), 0);

    // No digits, bad char in IDLE, bad char mid-command
    send_byte("P");
    send_byte(8'd13);
    drop();
    check("p_err", 32'(u_if.err), 1);
    check("p_code", 32'(u_if.err_code), 2);
    check("p_phase", 32'(u_if.phase), 50);

    send_byte("X");
    drop();
    check("x_err", 32'(u_if.err), 1);
    check("x_code", 32'(u_if.err_code), 0);
    check("x_busy", 32'(u_if.busy), 0);

    send_str("A1Z");
    send_byte("9");
    check("z_err", 32'(u_if.err), 1);
    check("z_code", 32'(u_if.err_code), 0);
    check("z_busy", 32'(u_if.busy), 1);
    send_byte(8'd13);
    check("flush_noerr", 32'(u_if.err), 0);
    check("flush_busy", 32'(u_if.busy), 1);
    drop();
    check("flush_done", 32'(u_if.busy), 0);
    check("flush_err", 32'(u_if.err), 0);
    check("flush_amp", 32'(u_if.amp), 200);
    check("flush_upd", 32'(u_if.cfg_update), 0);

    // Timeout after TMO idle cycles
    send_str("P12");
    drop();
    repeat (T - 1) @(negedge clk);
    check("tmo_early_err", 32'(u_if.err), 0);
    check("tmo_early_busy", 32'(u_if.busy), 1);
    @(negedge clk);
    check("tmo_err", 32'(u_if.err), 1);
    check("tmo_code", 32'(u_if.err_code), 3);
    check("tmo_busy", 32'(u_if.busy), 0);
    check("tmo_phase", 32'(u_if.phase), 50);
    check("tmo_upd", 32'(u_if.cfg_update), 0);

    // Byte landing on the expiry cycle keeps the command alive
    send_str("P12");
    drop();
    repeat (T - 2) @(negedge clk);
    send_byte("3");
    send_byte(8'd13);
    check("race_err", 32'(u_if.err), 0);
    check("race_busy", 32'(u_if.busy), 1);
    drop();
    check("race_phase", 32'(u_if.phase), 123);
    check("race_upd", 32'(u_if.cfg_update), 1);
    check("race_fld", 32'(u_if.cfg_field), 3);

    // Reset mid-command discards the partial value
    send_str("F99");
    @(negedge clk);
    u_if.rx_valid = 1'b0;
    rst           = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_freq", 32'(u_if.freq), 1);
    check("mid_rst_wave", 32'(u_if.wave_sel), 3);
    check("mid_rst_busy", 32'(u_if.busy), 0);
    send_byte("F");
    send_byte("7");
    send_byte(8'd13);
    drop();
    check("f7_freq", 32'(u_if.freq), 7);
    check("f7_upd", 32'(u_if.cfg_update), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/awg_cmd_ctrl.md
Name: awg_cmd_ctrl

Overview:
Serial command controller for the AWG. Consumes received UART bytes and parses multi-byte ASCII commands of the form <letter><decimal digits><CR|LF>. Range-checks each value and writes it to the waveform-select, frequency, amplitude or phase configuration registers that drive the DDS datapath. Pulses an update strobe on every accepted write and an error strobe with a code on every rejected command.

Parameters:
DEF_WAVE, 5'd3, reset value of wave_sel
DEF_FREQ, 12'd1, reset value of freq
DEF_AMP, 8'd50, reset value of amp
DEF_PHASE, 8'd50, reset value of phase
WAVE_MAX, 10, largest legal wave_sel value
MAX_DIGITS, 5, maximum digits per command
TIMEOUT_CYC, 24'd5_000_000, idle cycles mid-command before abort

Ports:
clk  in  1  system clock; single clock domain
rst  in  1  asynchronous, active-high reset
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe, rx_data valid
wave_sel  out  5  waveform select register
freq  out  12  frequency word register
amp  out  8  amplitude register
phase  out  8  phase register
cfg_update  out  1  one-cycle pulse, a register was written
cfg_field  out  2  field written: 0=W, 1=F, 2=A, 3=P; held until next write
err  out  1  one-cycle pulse, command rejected
err_code  out  2  0=bad char, 1=range/overflow, 2=no digits, 3=timeout; held until next err
busy  out  1  high while in DIGITS or FLUSH

Behaviour:
- Reset (async, rst=1): state=IDLE; wave_sel=DEF_WAVE, freq=DEF_FREQ, amp=DEF_AMP, phase=DEF_PHASE; cfg_update=0, cfg_field=0, err=0, err_code=0, busy=0; accumulator, digit count and timeout counter are cleared. Reset mid-command discards the partial command.
- All outputs are registered. Bytes are sampled only when rx_valid=1.
- IDLE:
  - Letters 'W'/'w', 'F'/'f', 'A'/'a', 'P'/'p' latch the field, clear acc and ndig, and go to DIGITS.
  - CR (13), LF (10) and space (32) are ignored silently.
  - Any other byte: err=1, err_code=0, remain in IDLE.
- DIGITS:
  - Byte '0'..'9' with ndig<MAX_DIGITS: acc <= acc*10 + (byte-48); ndig++. acc is 17 bits wide (99999 fits).
  - Digit with ndig==MAX_DIGITS: set the sticky ovf flag; acc is unchanged.
  - CR or LF terminator:
    - ndig==0: err, code 2.
    - ovf set, or acc > field max (W: WAVE_MAX, F: 4095, A: 255, P: 255): err, code 1.
    - Otherwise: write the field register with acc truncated to field width; cfg_field=field; cfg_update=1.
    - In all cases return to IDLE.
  - Any other byte: err=1, code 0; go to FLUSH.
- FLUSH: discard bytes until CR/LF, then go to IDLE. No further err pulses.
- Latency: the terminator is sampled at edge N. The register value, cfg_update and err all become visible after edge N, for exactly one cycle in the case of the strobes. The FSM is back in IDLE in the same cycle, so a byte arriving at edge N+1 is decoded normally. Back-to-back commands need no gap.
- Timeout:
  - In DIGITS or FLUSH, the counter increments each cycle without rx_valid and clears on any rx_valid.
  - When it reaches TIMEOUT_CYC-1: err=1, code 3; go to IDLE; no register write.
  - A byte that arrives in the same cycle as expiry wins: it is processed and the counter clears.
- Rejected commands never modify any config register. cfg_update and err are never asserted in the same cycle.
- busy=1 in DIGITS and FLUSH, 0 in IDLE; it is registered alongside the state.

Test Plan:
- After reset release with no input: wave_sel=3, freq=1, amp=50, phase=50; cfg_update, err and busy are all 0.
- Send "F1000\r": freq=1000 and cfg_update=1 with cfg_field=1 exactly one cycle after CR. Then send "a200\n" back-to-back: amp=200, cfg_field=2.
- Send "F4096\r" and then "F123456\r": err=1 with code 1 each time; freq is unchanged. "W11\r" gives err code 1; "W10\r" sets wave_sel=10.
- Send "P\r": err code 2, phase unchanged. Send "X": err code 0, stays IDLE. Send "A1Z9\r": one err code 0, and the FSM stays busy until CR; amp unchanged.
- Send "P12" then wait TIMEOUT_CYC cycles: err code 3, busy drops, phase=50. Repeat with a byte arriving on the expiry cycle: no timeout.
- Assert rst for one cycle mid-"F99", then send "F7\r": freq goes to reset value 1, then 7, with no stale digits carried over.
